sha1_msg_padder: RTL and testbench
==================================

Name: sha1_msg_padder

Overview:
- Upstream feeder for the SHA1 core. Accepts a message as a byte stream and produces FIPS 180-4 padded 512-bit blocks.
- Padding is: append 0x80, zero-fill, then a 64-bit big-endian bit length.
- Each block is presented on a valid/ready handshake. Top-level glue drives the core's start from blk_valid & blk_ready and holds blk_ready low until the core's done.
- Also emits first/last flags so the chaining logic knows when to reload the IV and when the digest is final.

Parameters:
- LEN_W, 64, width of the internal bit-length counter (16..64). Upper bits of the 64-bit length field are zero-extended.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  byte-beat valid
- in_ready  output  1  padder can accept a beat
- in_data  input  8  message byte
- in_keep  input  1  in_data carries a byte; 0 is legal only with in_last (end marker with no data)
- in_last  input  1  final beat of the message
- blk_valid  output  1  blk_data is valid; held until accepted
- blk_ready  input  1  downstream accepts the block
- blk_data  output  512  padded block; byte 0 at [511:504], byte 63 at [7:0]
- blk_first  output  1  block is the first of its message
- blk_last  output  1  block is the final block of its message

Behaviour:
- Beat transfer: occurs when in_valid & in_ready. Block transfer: occurs when blk_valid & blk_ready.
- States: FILL, PAD, OUT, OUT_PAD.
- Reset: state=FILL; ptr=0; bitlen=0; first_flag=1; buffer=0; blk_valid=0; blk_first=0; blk_last=0; in_ready=0 in the reset cycle.
- FILL:
  - in_ready=1.
  - Beat with keep=1: buf[ptr]=in_data; ptr+=1; bitlen+=8.
  - Beat with last=1: go to PAD (a byte carried on the same beat is stored first).
  - keep=1 filling byte 63 without last: go to OUT with blk_last=0.
  - keep=1 filling byte 63 with last: go to OUT_PAD (full data block, then a pad-only block).
- PAD (one cycle, in_ready=0):
  - buf[ptr]=0x80; bytes ptr+1..63 zeroed.
  - If ptr<=55: bytes 56..63 = bitlen (big-endian); go to OUT with blk_last=1.
  - Else: go to OUT with blk_last=0 and a pending-length marker set.
- OUT:
  - blk_valid=1; blk_data=buf; blk_first=first_flag. All three are stable while blk_ready=0.
  - On transfer: first_flag=0 and ptr=0.
    - Pending-length marker set: buffer zeroed, bytes 56..63=bitlen, re-enter OUT with blk_last=1, marker cleared.
    - Else if blk_last=1: first_flag=1, bitlen=0, go to FILL.
    - Else: go to FILL.
- OUT_PAD: same as OUT. On transfer, ptr=0 and go to PAD, which writes 0x80 at byte 0.
- blk_valid first rises 1 cycle after the beat that completes a block (PAD adds 1 more cycle).
- in_ready=0 in every state except FILL. No beats are accepted while a block is pending.
- Length overflow: bitlen wraps modulo 2^LEN_W. No error flag.
- Empty message (keep=0, last=1 at ptr=0): one block, 0x80 followed by zeros, length 0; first=last=1.
- rst in any state: everything returns to reset values next cycle and any partial block is dropped. The downstream side must tolerate blk_valid dropping on reset.

Decomposition:
- Package sha1_pkg holds:
  - SHA1_BLK_W=512, SHA1_DIG_W=160, SHA1_BYTES=64
  - SHA1_LEN_OFS=56, SHA1_PAD_BYTE=8'h80
  - state enum typedef (FILL, PAD, OUT, OUT_PAD)
- One sub-module: sha1_pad_mask. Combinational; given ptr and bitlen, it produces the 0x80/zero/length overlay and a byte mask for the PAD step.
- Buffer, counters and FSM stay in the top.

Test Plan:
- "test" (74 65 73 74, last on 4th byte) -> one block 0x74657374_80, zeros, length 0x...0020; first=last=1. This is the exact vector the SHA1 core bench uses.
- "abc" with blk_ready held 0 for 10 cycles -> blk_data 0x61626380, zeros, length 0x18; constant while stalled; in_ready=0 throughout.
- 55 bytes of 0x61 -> one block with 0x80 at byte 55 and length 0x1B8 at bytes 56..63. 56 bytes -> two blocks: the first with 0x80 at byte 56 and first=1, last=0; the second all zero with length 0x1C0, first=0, last=1.
- 64 bytes (last on 64th) -> block 1 is raw data (last=0); block 2 is 0x80 at byte 0, zeros, length 0x200 (last=1). Also: empty message (keep=0, last=1) -> single block 0x80, zeros, length 0.
- Back-to-back messages "a" then "bc" with blk_ready=1 -> two blocks, each first=last=1. The second has length 0x10, confirming bitlen and first_flag reset between messages.
- rst asserted for 1 cycle after 30 bytes of a message -> next cycle blk_valid=0 and in_ready=0. After reset, a fresh "abc" gives the correct single block with length 0x18.

Source files
------------

// File: rtl/sha1_pkg.sv
// Shared constants and types for the SHA1 message padder and its helpers.
//
// Contents:
//   SHA1_BLK_W    - width of one padded message block in bits
//   SHA1_DIG_W    - width of the SHA1 digest in bits
//   SHA1_BYTES    - bytes per block
//   SHA1_LEN_OFS  - byte index where the 64-bit length field starts
//   SHA1_PAD_BYTE - the marker byte written right after the message
//   padState_t    - padder FSM states
package sha1_pkg;

  localparam int SHA1_BLK_W   = 512;
  localparam int SHA1_DIG_W   = 160;
  localparam int SHA1_BYTES   = 64;
  localparam int SHA1_LEN_OFS = 56;
  localparam logic [7:0] SHA1_PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    OUT,
    OUT_PAD
  } padState_t;

endpackage

// File: rtl/sha1_pad_mask.sv
// Combinational overlay generator for the padding step.
//
// Given the byte pointer where the message ended and the message bit length,
// it produces the bytes that padding writes into the block buffer and a
// per-byte mask saying which buffer bytes get replaced.
//
// Ports:
//   i_ptr     - first byte index not holding message data (0..63)
//   i_len     - message length in bits, already zero-extended to 64 bits
//   o_data    - overlay block; byte 0 at [511:504], byte 63 at [7:0]
//   o_mask    - bit i set means buffer byte i is taken from o_data
//   o_lenFits - the length field fits in this block (pointer at or before 55)
module sha1_pad_mask
  import sha1_pkg::*;
(
  input  logic [5:0]   i_ptr,
  input  logic [63:0]  i_len,
  output logic [511:0] o_data,
  output logic [63:0]  o_mask,
  output logic         o_lenFits
);

  // Every byte from the pointer onwards is rewritten: the pointer byte gets
  // the 0x80 marker, the rest become zero, and when there is room for it the
  // big-endian length lands in the last eight bytes.
  always_comb begin
    o_data    = '0;
    o_mask    = '0;
    o_lenFits = (i_ptr <= 6'(SHA1_LEN_OFS - 1));
    for (int i = 0; i < SHA1_BYTES; i++) begin
      if (6'(i) >= i_ptr) begin
        o_mask[i] = 1'b1;
      end
      if (6'(i) == i_ptr) begin
        o_data[511 - 8*i -: 8] = SHA1_PAD_BYTE;
      end
      if (o_lenFits && (i >= SHA1_LEN_OFS)) begin
        o_data[511 - 8*i -: 8] = i_len[63 - 8*(i - SHA1_LEN_OFS) -: 8];
      end
    end
  end

endmodule

// File: rtl/sha1_msg_padder.sv
// SHA1 message padder: turns a byte stream into padded 512-bit blocks.
//
// Bytes are collected into a 64-byte buffer. When the message ends, a 0x80
// marker, zero fill and the 64-bit big-endian bit length are added, spilling
// into an extra block when the length does not fit. Blocks are handed out on
// a valid/ready handshake together with first/last flags for chaining.
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   in_valid  - byte beat valid
//   in_ready  - padder can accept a beat
//   in_data   - message byte
//   in_keep   - in_data carries a byte (0 only together with in_last)
//   in_last   - final beat of the message
//   blk_valid - blk_data is valid, held until accepted
//   blk_ready - downstream accepts the block
//   blk_data  - padded block; byte 0 at [511:504], byte 63 at [7:0]
//   blk_first - block is the first of its message
//   blk_last  - block is the final block of its message
module sha1_msg_padder
  import sha1_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_keep,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);

  padState_t        r_state;
  padState_t        w_nextState;
  logic [7:0]       r_buf [SHA1_BYTES];
  logic [5:0]       r_ptr;
  logic [LEN_W-1:0] r_bitlen;
  logic             r_first;
  logic             r_last;
  logic             r_pend;
  logic             r_inReady;

  logic             w_beat;
  logic             w_xfer;
  logic             w_blkValid;
  logic             w_ptrAtEnd;
  logic [63:0]      w_len64;
  logic [511:0]     w_padData;
  logic [63:0]      w_padMask;
  logic             w_lenFits;

  assign w_blkValid = (r_state == OUT) || (r_state == OUT_PAD);
  assign w_beat     = in_valid & r_inReady;
  assign w_xfer     = w_blkValid & blk_ready;
  assign w_ptrAtEnd = (r_ptr == 6'(SHA1_BYTES - 1));
  assign w_len64    = 64'(r_bitlen);

  assign in_ready   = r_inReady;
  assign blk_valid  = w_blkValid;
  assign blk_first  = w_blkValid & r_first;
  assign blk_last   = w_blkValid & r_last;

  sha1_pad_mask u_padMask (
    .i_ptr     (r_ptr),
    .i_len     (w_len64),
    .o_data    (w_padData),
    .o_mask    (w_padMask),
    .o_lenFits (w_lenFits)
  );

  // Flatten the byte buffer onto the block bus, byte 0 in the top bits.
  always_comb begin
    blk_data = '0;
    for (int i = 0; i < SHA1_BYTES; i++) begin
      blk_data[511 - 8*i -: 8] = r_buf[i];
    end
  end

  // State register for the padder FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A full buffer that also ends the message must first be
  // sent as raw data (OUT_PAD) and then padded from byte 0. OUT returns to
  // FILL unless a length-only block is still owed, in which case it stays in
  // OUT to present that block.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      FILL: begin
        if (w_beat) begin
          if (in_keep && w_ptrAtEnd) begin
            w_nextState = in_last ? OUT_PAD : OUT;
          end else if (in_last) begin
            w_nextState = PAD;
          end
        end
      end
      PAD: begin
        w_nextState = OUT;
      end
      OUT: begin
        if (w_xfer && !r_pend) begin
          w_nextState = FILL;
        end
      end
      OUT_PAD: begin
        if (w_xfer) begin
          w_nextState = PAD;
        end
      end
      default: begin
        w_nextState = FILL;
      end
    endcase
  end

  // Buffer, counters and flags. in_ready is registered from the next state so
  // it is low in the cycle after reset and whenever a block is pending. The
  // pending marker remembers that the length did not fit and a zero block
  // carrying only the length must follow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SHA1_BYTES; i++) begin
        r_buf[i] <= 8'h00;
      end
      r_ptr     <= '0;
      r_bitlen  <= '0;
      r_first   <= 1'b1;
      r_last    <= 1'b0;
      r_pend    <= 1'b0;
      r_inReady <= 1'b0;
    end else begin
      r_inReady <= (w_nextState == FILL);
      unique case (r_state)
        FILL: begin
          if (w_beat && in_keep) begin
            r_buf[r_ptr] <= in_data;
            r_ptr        <= r_ptr + 6'd1;
            r_bitlen     <= r_bitlen + LEN_W'(8);
            if (w_ptrAtEnd) begin
              r_last <= 1'b0;
            end
          end
        end
        PAD: begin
          for (int i = 0; i < SHA1_BYTES; i++) begin
            if (w_padMask[i]) begin
              r_buf[i] <= w_padData[511 - 8*i -: 8];
            end
          end
          r_last <= w_lenFits;
          r_pend <= !w_lenFits;
        end
        OUT: begin
          if (w_xfer) begin
            r_first <= 1'b0;
            r_ptr   <= '0;
            if (r_pend) begin
              for (int i = 0; i < SHA1_BYTES; i++) begin
                if (i >= SHA1_LEN_OFS) begin
                  r_buf[i] <= w_len64[63 - 8*(i - SHA1_LEN_OFS) -: 8];
                end else begin
                  r_buf[i] <= 8'h00;
                end
              end
              r_last <= 1'b1;
              r_pend <= 1'b0;
            end else if (r_last) begin
              r_first  <= 1'b1;
              r_bitlen <= '0;
            end
          end
        end
        OUT_PAD: begin
          if (w_xfer) begin
            r_first <= 1'b0;
            r_ptr   <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Self-checking bench for sha1_msg_padder. Expected blocks are queued when a
// message is issued and popped by an independent monitor whenever the DUT
// hands over a block.
module tb_sha1_msg_padder;

  typedef struct {
    logic [511:0] data;
    bit           first;
    bit           last;
  } blk_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_keep;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  blk_t expQ[$];
  int   total = 0;
  int   bad   = 0;
  bit   stallHold = 1'b0;
  bit   readyHold = 1'b0;

  sha1_msg_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .in_last   (in_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: message, 0x80, zeros up to 56 mod 64, 64-bit bit length,
  // cut into 64-byte blocks.
  function automatic void buildBlocks(input byte unsigned msg[$]);
    byte unsigned s[$];
    longint unsigned bits;
    int nBlk;
    blk_t e;
    s = msg;
    bits = 64'(msg.size()) * 64'd8;
    s.push_back(8'h80);
    while ((s.size() % 64) != 56) s.push_back(8'h00);
    for (int k = 7; k >= 0; k--) s.push_back(8'(bits >> (8*k)));
    nBlk = s.size() / 64;
    for (int b = 0; b < nBlk; b++) begin
      e.data = '0;
      for (int j = 0; j < 64; j++) e.data[511 - 8*j -: 8] = s[64*b + j];
      e.first = (b == 0);
      e.last  = (b == nBlk - 1);
      expQ.push_back(e);
    end
  endfunction

  function automatic void pushConst(input logic [511:0] d);
    blk_t e;
    e.data = d;
    e.first = 1'b1;
    e.last = 1'b1;
    expQ.push_back(e);
  endfunction

  // Present one beat and hold it until the DUT takes it (bounded).
  task automatic sendBeat(input byte unsigned d, input bit k, input bit l);
    int budget = 0;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
      end else if (++budget > 3000) begin
        total++;
        bad++;
        $display("[TB] FAIL beat_timeout actual=no_accept required=accept");
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_keep  = 1'b0;
    in_last  = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send a message; optionally end it with a separate no-data last marker.
  task automatic applyStimulus(input byte unsigned msg[$], input bit sendLast, input bit marker);
    int n = msg.size();
    if (n == 0) begin
      if (sendLast) sendBeat(8'h00, 1'b0, 1'b1);
    end else begin
      for (int i = 0; i < n; i++) begin
        sendBeat(msg[i], 1'b1, sendLast && !marker && (i == n - 1));
      end
      if (sendLast && marker) sendBeat(8'h00, 1'b0, 1'b1);
    end
  endtask

  task automatic waitDrain();
    int budget = 0;
    while (expQ.size() != 0 && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    #1;
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout pending=%0d required=0", expQ.size());
    end
  endtask

  // Downstream ready: random backpressure unless a test pins it.
  initial begin
    blk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stallHold) blk_ready = 1'b0;
      else if (readyHold) blk_ready = 1'b1;
      else blk_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: on every falling edge check stall stability and in_ready, and
  // pop/compare the expected block whenever a transfer is about to happen.
  initial begin
    logic [511:0] heldData;
    bit heldFirst, heldLast, holdValid;
    blk_t e;
    holdValid = 1'b0;
    heldData = '0;
    heldFirst = 1'b0;
    heldLast = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        holdValid = 1'b0;
      end else begin
        if (holdValid && blk_valid) begin
          checkOutput("stall_data", blk_data, heldData);
          checkOutput("stall_flags", {510'b0, blk_first, blk_last}, {510'b0, heldFirst, heldLast});
        end
        if (blk_valid) checkOutput("in_ready_busy", {511'b0, in_ready}, 512'd0);
        if (blk_valid && blk_ready) begin
          holdValid = 1'b0;
          if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_block actual=%0h required=none", blk_data);
          end else begin
            e = expQ.pop_front();
            checkOutput("blk_data", blk_data, e.data);
            checkOutput("blk_first", {511'b0, blk_first}, {511'b0, e.first});
            checkOutput("blk_last", {511'b0, blk_last}, {511'b0, e.last});
          end
        end else if (blk_valid) begin
          holdValid = 1'b1;
          heldData  = blk_data;
          heldFirst = blk_first;
          heldLast  = blk_last;
        end else begin
          holdValid = 1'b0;
        end
      end
    end
  end

  initial begin
    byte unsigned msg[$];
    int lens[$];
    int budget;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_keep = 1'b0;
    in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_state", {508'b0, blk_valid, in_ready, blk_first, blk_last}, 512'd0);
    @(posedge clk);
    #1;

    $display("[TB] directed: test");
    pushConst({32'h74657374, 8'h80, 408'h0, 64'h20});
    msg = '{8'h74, 8'h65, 8'h73, 8'h74};
    applyStimulus(msg, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] directed: abc with stall");
    stallHold = 1'b1;
    pushConst({24'h616263, 8'h80, 416'h0, 64'h18});
    msg = '{8'h61, 8'h62, 8'h63};
    applyStimulus(msg, 1'b1, 1'b0);
    budget = 0;
    while (!blk_valid && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("stall_valid", {511'b0, blk_valid}, {511'b0, 1'b1});
    repeat (10) @(negedge clk);
    stallHold = 1'b0;
    waitDrain();

    $display("[TB] directed: boundary lengths");
    lens = '{55, 56, 64, 0, 63, 65, 119, 120, 128};
    foreach (lens[k]) begin
      msg = {};
      for (int i = 0; i < lens[k]; i++) msg.push_back((k < 3) ? 8'h61 : 8'($urandom));
      buildBlocks(msg);
      applyStimulus(msg, 1'b1, 1'b0);
    end
    waitDrain();

    $display("[TB] directed: back-to-back a, bc");
    readyHold = 1'b1;
    msg = '{8'h61};
    buildBlocks(msg);
    applyStimulus(msg, 1'b1, 1'b0);
    msg = '{8'h62, 8'h63};
    buildBlocks(msg);
    applyStimulus(msg, 1'b1, 1'b0);
    waitDrain();
    readyHold = 1'b0;

    $display("[TB] random messages");
    for (int m = 0; m < 16; m++) begin
      msg = {};
      for (int i = 0; i < $urandom_range(0, 140); i++) msg.push_back(8'($urandom));
      buildBlocks(msg);
      applyStimulus(msg, 1'b1, 1'($urandom_range(0, 1)));
    end
    waitDrain();

    $display("[TB] reset mid-message");
    msg = {};
    for (int i = 0; i < 30; i++) msg.push_back(8'($urandom));
    applyStimulus(msg, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset", {510'b0, blk_valid, in_ready}, 512'd0);
    @(posedge clk);
    #1;
    pushConst({24'h616263, 8'h80, 416'h0, 64'h18});
    msg = '{8'h61, 8'h62, 8'h63};
    applyStimulus(msg, 1'b1, 1'b0);
    waitDrain();

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
